// File: rtl/shift_out_ctrl.sv
// Framed, paced parallel-to-serial controller: accepts a word on valid/ready, emits it MSB-first.
// Optional even-parity bit after the data bits is enabled by defining SHIFT_OUT_CTRL_PARITY_EN.
module shift_out_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             move_load_o,
  output logic             serial_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);

`ifdef SHIFT_OUT_CTRL_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PAR = 2'd2, S_DONE = 2'd3} state_t;
  logic r_parity;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_div_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_div_end;
  logic w_last_bit;

  assign w_accept   = valid_i & r_ready;
  assign w_div_end  = (r_div_cnt == CNT_W'(DIV - 1));
  assign w_last_bit = (r_bit_cnt == BIT_W'(WIDTH - 1));

  assign ready_o     = r_ready;
  assign move_load_o = ~w_accept;
  // The shift register MSB is the registered serial output; it is cleared outside a frame.
  assign serial_o    = r_sreg[WIDTH-1];
  assign busy_o      = r_busy;
  assign done_o      = r_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_sreg    <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SHIFT_OUT_CTRL_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sreg    <= data_i;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
`ifdef SHIFT_OUT_CTRL_PARITY_EN
            r_parity  <= ^data_i;
`endif
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            if (w_last_bit) begin
`ifdef SHIFT_OUT_CTRL_PARITY_EN
              r_sreg  <= {r_parity, {(WIDTH-1){1'b0}}};
              r_state <= S_PAR;
`else
              r_sreg  <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_sreg    <= {r_sreg[WIDTH-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
          end
        end
`ifdef SHIFT_OUT_CTRL_PARITY_EN
        S_PAR: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_sreg    <= '0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
          end
        end
`endif
        S_DONE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_sreg  <= '0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_out_ctrl.sv
// Directed bench for shift_out_ctrl: three instances (DIV=1, 3, 2) sharing clock and reset.
module tb_shift_out_ctrl;

`ifdef SHIFT_OUT_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       rst;
  logic       val [3];
  logic [3:0] dat [3];
  logic       rdy [3];
  logic       mvl [3];
  logic       ser [3];
  logic       bsy [3];
  logic       dn  [3];

  int n_chk  = 0;
  int n_fail = 0;

  shift_out_ctrl #(.WIDTH(4), .DIV(1)) u_div1 (
    .clk_i(clk), .rst_i(rst), .valid_i(val[0]), .data_i(dat[0]), .ready_o(rdy[0]),
    .move_load_o(mvl[0]), .serial_o(ser[0]), .busy_o(bsy[0]), .done_o(dn[0]));
  shift_out_ctrl #(.WIDTH(4), .DIV(3)) u_div3 (
    .clk_i(clk), .rst_i(rst), .valid_i(val[1]), .data_i(dat[1]), .ready_o(rdy[1]),
    .move_load_o(mvl[1]), .serial_o(ser[1]), .busy_o(bsy[1]), .done_o(dn[1]));
  shift_out_ctrl #(.WIDTH(4), .DIV(2)) u_div2 (
    .clk_i(clk), .rst_i(rst), .valid_i(val[2]), .data_i(dat[2]), .ready_o(rdy[2]),
    .move_load_o(mvl[2]), .serial_o(ser[2]), .busy_o(bsy[2]), .done_o(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one frame from its accept cycle (c=0) through the done cycle; returns at the start of the next cycle.
  task automatic frame(input int k, input int div, input logic [3:0] word, input logic pbit,
                       input int done_cyc, input bit hold, input logic [3:0] nxt, input bit poke);
    logic v;
    logic exp_ser;
    val[k] = 1'b1;
    dat[k] = word;
    v      = 1'b1;
    for (int c = 0; c <= done_cyc; c++) begin
      @(negedge clk);
      exp_ser = 1'b0;
      if (c >= 1 && c <= 4 * div) exp_ser = word[3 - (c - 1) / div];
      else if (P == 1 && c > 4 * div && c <= 5 * div) exp_ser = pbit;
      check($sformatf("u%0d w%h c%0d serial", k, word, c), int'(ser[k]), int'(exp_ser));
      check($sformatf("u%0d w%h c%0d ready", k, word, c), int'(rdy[k]), (c == 0) ? 1 : 0);
      check($sformatf("u%0d w%h c%0d busy", k, word, c), int'(bsy[k]), (c != 0) ? 1 : 0);
      check($sformatf("u%0d w%h c%0d done", k, word, c), int'(dn[k]), (c == done_cyc) ? 1 : 0);
      check($sformatf("u%0d w%h c%0d move_load", k, word, c), int'(mvl[k]), (v && c == 0) ? 0 : 1);
      @(posedge clk);
      #1;
      if (c == 0) begin
        if (hold) dat[k] = nxt;
        else begin
          val[k] = 1'b0;
          v      = 1'b0;
        end
      end
      if (poke && c == 1) begin
        dat[k] = 4'hF;
        val[k] = 1'b1;
        v      = 1'b1;
      end
      if (poke && c == 2) begin
        val[k] = 1'b0;
        v      = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input int k, input string tag);
    @(negedge clk);
    check({tag, " ready"}, int'(rdy[k]), 1);
    check({tag, " busy"}, int'(bsy[k]), 0);
    check({tag, " serial"}, int'(ser[k]), 0);
    check({tag, " done"}, int'(dn[k]), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      val[i] = 1'b0;
      dat[i] = 4'h0;
    end
    // A word offered during reset must not be accepted.
    val[0] = 1'b1;
    dat[0] = 4'hC;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset u%0d ready", i), int'(rdy[i]), 1);
      check($sformatf("reset u%0d busy", i), int'(bsy[i]), 0);
      check($sformatf("reset u%0d serial", i), int'(ser[i]), 0);
      check($sformatf("reset u%0d done", i), int'(dn[i]), 0);
    end
    check("reset u0 move_load valid", int'(mvl[0]), 0);
    check("reset u1 move_load idle", int'(mvl[1]), 1);
    val[0] = 1'b0;
    @(posedge clk);
    #1;
    idle_check(0, "after reset u0");

    // Basic frame, DIV=1.
    frame(0, 1, 4'b1011, 1'b1, 5 + P, 1'b0, 4'h0, 1'b0);
    idle_check(0, "basic end");

    // Paced frame, DIV=3.
    frame(1, 3, 4'b0110, 1'b0, 13 + 3 * P, 1'b0, 4'h0, 1'b0);
    idle_check(1, "paced end");

    // Back-to-back with valid held high.
    frame(0, 1, 4'hA, 1'b0, 5 + P, 1'b1, 4'h5, 1'b0);
    frame(0, 1, 4'h5, 1'b0, 5 + P, 1'b0, 4'h0, 1'b0);
    idle_check(0, "b2b end");

    // Inputs poked during SHIFT are ignored.
    frame(0, 1, 4'b1001, 1'b0, 5 + P, 1'b0, 4'h0, 1'b1);
    idle_check(0, "ignore end 1");
    idle_check(0, "ignore end 2");

    // Reset in the cycle after bit 1 of 4'b1111.
    val[0] = 1'b1;
    dat[0] = 4'b1111;
    @(negedge clk);
    check("rst-mid c0 ready", int'(rdy[0]), 1);
    @(posedge clk);
    #1;
    val[0] = 1'b0;
    @(negedge clk);
    check("rst-mid c1 serial", int'(ser[0]), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst-mid c2 serial", int'(ser[0]), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) idle_check(0, $sformatf("rst-mid after %0d", i));

    // DIV=2 frames; parity bit visible only with the macro defined.
    frame(2, 2, 4'b0111, 1'b1, 9 + 2 * P, 1'b0, 4'h0, 1'b0);
    idle_check(2, "div2 0111 end");
    frame(2, 2, 4'b0011, 1'b0, 9 + 2 * P, 1'b0, 4'h0, 1'b0);
    idle_check(2, "div2 0011 end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
